// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keymap, debounce states and frame classes for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} deb_state_t;

    typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_class_t;

    // Indexed [row][col]; row 0 is the top row, col 0 the leftmost column.
    localparam logic [3:0] KEYMAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - accepted-key output bundle from the scanner to the lock stage
interface keypad_scanner_if;

    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (output key_code, key_valid, key_held);
    modport slave  (input  key_code, key_valid, key_held);

endinterface

// File: rtl/keypad_press_fsm.sv
// rtl/keypad_press_fsm.sv - per-frame debounce of press/release, one key_valid pulse per press
module keypad_press_fsm
    import keypad_pkg::*;
#(
    parameter int STABLE_SCANS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_end,
    input  frame_class_t frame_class,
    input  logic [3:0]   frame_code,
    output logic [3:0]   key_code,
    output logic         key_valid,
    output logic         key_held
);

    localparam int CW = $clog2(STABLE_SCANS + 1);

    deb_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    cand, cand_n;
    logic [3:0]    code_n;
    logic          valid_n, held_n;
    logic          hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

    // cnt only advances while below STABLE_SCANS, so it saturates without wrapping.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = key_code;
        held_n  = key_held;
        valid_n = 1'b0;
        hit     = (int'(cnt) + 1) >= STABLE_SCANS;
        if (frame_end) begin
            unique case (state)
                IDLE: begin
                    if (frame_class == SINGLE) begin
                        cand_n = frame_code;
                        if (STABLE_SCANS == 1) begin
                            code_n  = frame_code;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            cnt_n   = '0;
                            state_n = PRESSED;
                        end else begin
                            cnt_n   = CW'(1);
                            state_n = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (frame_class == SINGLE && frame_code == cand) begin
                        if (hit) begin
                            code_n  = cand;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            cnt_n   = '0;
                            state_n = PRESSED;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
                PRESSED: begin
                    if (frame_class == NONE) begin
                        if (STABLE_SCANS == 1) begin
                            held_n  = 1'b0;
                            cnt_n   = '0;
                            state_n = IDLE;
                        end else begin
                            cnt_n   = CW'(1);
                            state_n = DEB_REL;
                        end
                    end
                end
                DEB_REL: begin
                    if (frame_class == NONE) begin
                        if (hit) begin
                            held_n  = 1'b0;
                            cnt_n   = '0;
                            state_n = IDLE;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = PRESSED;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scan, row sync, frame classification and debounce
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int SCAN_US      = 1000,
    parameter int STABLE_SCANS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        row,
    output logic [3:0]        col,
    keypad_scanner_if.master  key
);

    localparam int SLOT = CLK_FREQ / 1_000_000 * SCAN_US;
    localparam int SW   = $clog2(SLOT);

    logic [SW-1:0] slot_cnt;
    logic [1:0]    col_idx;
    logic [3:0]    row_meta, row_sync;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;

    logic          slot_end, frame_end;
    logic [2:0]    n_low, sum;
    logic [1:0]    tot_cnt;
    logic [3:0]    slot_code, tot_code;
    frame_class_t  frame_class;

    assign col = ~(4'b0001 << col_idx);

    // Idle rows read high, so the synchronizer resets to all-released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    always_comb begin
        slot_end  = (slot_cnt == SW'(SLOT - 1));
        frame_end = slot_end && (col_idx == 2'd3);
        n_low     = '0;
        slot_code = '0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r]) begin
                n_low     = n_low + 3'd1;
                slot_code = KEYMAP[r][col_idx];
            end
        end
        // Lows beyond two never change the class, so the running count saturates at 2.
        sum         = {1'b0, acc_cnt} + n_low;
        tot_cnt     = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        tot_code    = (acc_cnt == 2'd0 && n_low == 3'd1) ? slot_code : acc_code;
        frame_class = (tot_cnt == 2'd0) ? NONE : (tot_cnt == 2'd1) ? SINGLE : MULTI;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            col_idx  <= '0;
            acc_cnt  <= '0;
            acc_code <= '0;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + SW'(1);
            if (slot_end) begin
                col_idx <= col_idx + 2'd1;
                if (frame_end) begin
                    acc_cnt  <= '0;
                    acc_code <= '0;
                end else begin
                    acc_cnt  <= tot_cnt;
                    acc_code <= tot_code;
                end
            end
        end
    end

    keypad_press_fsm #(
        .STABLE_SCANS(STABLE_SCANS)
    ) u_press_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_end  (frame_end),
        .frame_class(frame_class),
        .frame_code (tot_code),
        .key_code   (key.key_code),
        .key_valid  (key.key_valid),
        .key_held   (key.key_held)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a matrix keypad model
module tb_keypad_scanner;

    typedef struct {
        logic [15:0] mask;
        int          frames;
        int          pulse_frame;
        logic [3:0]  code;
        logic        held;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [3:0] code;
    } exp_t;

    localparam int NSEG = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] mask = '0;
    int          cyc;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb[$];
    vec_t        tbl[NSEG];

    keypad_scanner_if kif();

    keypad_scanner #(
        .CLK_FREQ    (1_000_000),
        .SCAN_US     (4),
        .STABLE_SCANS(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .row  (row),
        .col  (col),
        .key  (kif)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            row[r] = ~|(mask[r*4 +: 4] & ~col);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [15:0] kb(input int r, input int c);
        return 16'(1) << (r * 4 + c);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0] exp_col;
            exp_col = ~(4'b0001 << ((cyc / 4) % 4));
            check("col", 32'(col), 32'(exp_col));
            if (kif.key_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_key_valid: got code %0h at cyc %0d expected none", kif.key_code, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    check("pulse_code", 32'(kif.key_code), 32'(e.code));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        tbl[0]  = '{16'h0000,          10, 0, 4'h0, 1'b0};
        tbl[1]  = '{kb(1,1),            6, 3, 4'h5, 1'b1};
        tbl[2]  = '{16'h0000,           2, 0, 4'h5, 1'b1};
        tbl[3]  = '{16'h0000,           1, 0, 4'h5, 1'b0};
        tbl[4]  = '{kb(2,2),            2, 0, 4'h5, 1'b0};
        tbl[5]  = '{16'h0000,           1, 0, 4'h5, 1'b0};
        tbl[6]  = '{kb(2,2),            4, 3, 4'h9, 1'b1};
        tbl[7]  = '{16'h0000,           4, 0, 4'h9, 1'b0};
        tbl[8]  = '{kb(0,3) | kb(1,0),  5, 0, 4'h9, 1'b0};
        tbl[9]  = '{16'h0000,           1, 0, 4'h9, 1'b0};
        tbl[10] = '{kb(1,1),            3, 3, 4'h5, 1'b1};
        tbl[11] = '{kb(1,1) | kb(2,3),  2, 0, 4'h5, 1'b1};
        tbl[12] = '{kb(2,3),            2, 0, 4'h5, 1'b1};
        tbl[13] = '{16'h0000,           3, 0, 4'h5, 1'b0};
        tbl[14] = '{kb(3,3),            3, 3, 4'hD, 1'b1};
        tbl[15] = '{16'h0000,           3, 0, 4'hD, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        check("reset_col", 32'(col), 32'h0000_000E);
        check("reset_code", 32'(kif.key_code), 32'h0);
        check("reset_valid", 32'(kif.key_valid), 32'h0);
        check("reset_held", 32'(kif.key_held), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NSEG; i++) begin
            start = cyc;
            mask  = tbl[i].mask;
            if (tbl[i].pulse_frame != 0)
                sb.push_back('{start + 16 * tbl[i].pulse_frame, tbl[i].code});
            repeat (16 * tbl[i].frames) @(negedge clk);
            #1;
            check($sformatf("seg%0d_held", i), 32'(kif.key_held), 32'(tbl[i].held));
            check($sformatf("seg%0d_code", i), 32'(kif.key_code), 32'(tbl[i].code));
            check($sformatf("seg%0d_pending", i), 32'(sb.size()), 32'h0);
        end

        // Reset lands mid-way through frame 2 of a '0' press.
        mask = kb(3, 0);
        repeat (22) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_col", 32'(col), 32'h0000_000E);
        check("midreset_code", 32'(kif.key_code), 32'h0);
        check("midreset_valid", 32'(kif.key_valid), 32'h0);
        check("midreset_held", 32'(kif.key_held), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{48, 4'h0});
        repeat (47) @(negedge clk);
        #1;
        check("postreset_held_early", 32'(kif.key_held), 32'h0);
        @(negedge clk);
        #1;
        check("postreset_held", 32'(kif.key_held), 32'h1);
        check("postreset_code", 32'(kif.key_code), 32'h0);
        mask = '0;
        repeat (64) @(negedge clk);
        #1;
        check("final_pending", 32'(sb.size()), 32'h0);
        check("final_held", 32'(kif.key_held), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
